// File: rtl/rd_stream_stage.sv
// ============================================================================
// rd_stream_stage : FIFO pull-port to valid/ready stream, 2-entry prefetch
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rd_stream_stage #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  rclk,
   input  logic                  rrst,
   input  logic                  fifo_empty,
   output logic                  fifo_r_en,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [1:0]            level,
   output logic                  err_ovf
);

   logic [1:0]            cnt_q;
   logic [1:0]            cnt_d;
   logic                  inflight_q;
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic                  err_ovf_q;
   logic [DATA_WIDTH-1:0] entry_q [2];

   logic                  pop;
   logic                  push;
   logic                  ovf;
   logic [2:0]            outstanding;

   assign m_valid = (cnt_q != 2'd0);
   assign pop     = m_valid & m_ready;

   // Words held or arriving after this cycle's pop; never underflows since pop implies cnt_q >= 1.
   assign outstanding = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign fifo_r_en   = ~fifo_empty & (outstanding <= 3'd1);

   assign ovf  = inflight_q & (cnt_q == 2'd2) & ~pop;
   assign push = inflight_q & ~ovf;

   always_comb begin
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         cnt_q      <= 2'd0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         err_ovf_q  <= 1'b0;
         entry_q[0] <= '0;
         entry_q[1] <= '0;
      end else begin
         inflight_q <= fifo_r_en;
         cnt_q      <= cnt_d;
         if (push) begin
            entry_q[wr_ptr_q] <= fifo_rdata;
            wr_ptr_q          <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         if (ovf) begin
            err_ovf_q <= 1'b1;
         end
      end
   end

   assign m_data  = entry_q[rd_ptr_q];
   assign level   = cnt_q;
   assign err_ovf = err_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_rd_stream_stage.sv
// ============================================================================
// tb_rd_stream_stage : directed vectors plus scoreboard for rd_stream_stage
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rd_stream_stage;

   logic       rclk       = 1'b0;
   logic       rrst       = 1'b1;
   logic       fifo_empty = 1'b1;
   logic       m_ready    = 1'b0;
   logic [7:0] fifo_rdata = 8'h00;
   logic       fifo_r_en;
   logic       m_valid;
   logic [7:0] m_data;
   logic [1:0] level;
   logic       err_ovf;

   rd_stream_stage #(.DATA_WIDTH(8)) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .fifo_empty(fifo_empty),
      .fifo_r_en (fifo_r_en),
      .fifo_rdata(fifo_rdata),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .level     (level),
      .err_ovf   (err_ovf)
   );

   always #5 rclk = ~rclk;

   typedef struct {
      bit         emp;
      bit         rdy;
      bit         ren;
      bit         vld;
      logic [7:0] dat;
      logic [1:0] lvl;
   } vec_t;

   vec_t       tv1 [4];
   vec_t       tv2 [13];
   logic [7:0] src [0:2047];
   int         ncmp = 0;
   int         nerr = 0;
   int         ridx = 0;
   int         sidx = 0;
   int         rend = 0;
   bit         rd_pend;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Upstream model: empty is forced once every word of the burst has been read.
   task automatic drive(input bit emp, input bit rdy);
      fifo_empty = emp | (ridx >= rend);
      m_ready    = rdy;
      #1;
      if (fifo_r_en && fifo_empty) chk("ren_while_empty", 32'd1, 32'd0);
      if (m_valid && m_ready) begin
         if (sidx >= rend) chk("sb_extra_word", 32'd1, 32'd0);
         else chk($sformatf("sb_data[%0d]", sidx), {24'd0, m_data}, {24'd0, src[sidx]});
         sidx++;
      end
   endtask

   task automatic tick();
      rd_pend = fifo_r_en;
      @(posedge rclk);
      #1;
      if (rd_pend && ridx < 2048) begin
         fifo_rdata = src[ridx];
         ridx++;
      end else begin
         fifo_rdata = 8'($urandom);
      end
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      drive(v.emp, v.rdy);
      chk({tag, ".ren"},   {31'd0, fifo_r_en}, {31'd0, v.ren});
      chk({tag, ".valid"}, {31'd0, m_valid},   {31'd0, v.vld});
      chk({tag, ".level"}, {30'd0, level},     {30'd0, v.lvl});
      if (v.vld) chk({tag, ".data"}, {24'd0, m_data}, {24'd0, v.dat});
      tick();
   endtask

   initial begin
      int first, last, nv, maxl, cyc;

      // {emp, rdy, ren, vld, dat, lvl}
      tv1[0] = '{0, 1, 1, 0, 8'h00, 2'd0};
      tv1[1] = '{1, 1, 0, 0, 8'h00, 2'd0};
      tv1[2] = '{1, 1, 0, 1, 8'hA5, 2'd1};
      tv1[3] = '{1, 1, 0, 0, 8'h00, 2'd0};

      tv2[0] = '{0, 0, 1, 0, 8'h00, 2'd0};
      tv2[1] = '{0, 0, 1, 0, 8'h00, 2'd0};
      tv2[2] = '{0, 0, 0, 1, 8'h01, 2'd1};
      for (int i = 3; i < 10; i++) tv2[i] = '{0, 0, 0, 1, 8'h01, 2'd2};
      tv2[10] = '{0, 1, 1, 1, 8'h01, 2'd2};
      tv2[11] = '{0, 1, 1, 1, 8'h02, 2'd1};
      tv2[12] = '{0, 1, 1, 1, 8'h03, 2'd1};

      src[0] = 8'hA5;
      for (int i = 0; i < 16; i++) begin
         src[1 + i]  = 8'(i + 1);
         src[17 + i] = 8'(i + 1);
      end
      for (int i = 33; i < 2048; i++) src[i] = 8'($urandom);

      // Reset held with the FIFO empty
      @(posedge rclk);
      #1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0);
         chk("rst.ren",   {31'd0, fifo_r_en}, 32'd0);
         chk("rst.valid", {31'd0, m_valid},   32'd0);
         chk("rst.level", {30'd0, level},     32'd0);
         chk("rst.err",   {31'd0, err_ovf},   32'd0);
         chk("rst.data",  {24'd0, m_data},    32'd0);
         tick();
      end
      rrst = 1'b0;
      drive(1'b1, 1'b0);
      tick();

      // Single word, first-word latency
      rend = 1;
      for (int i = 0; i < 4; i++) apply_vec(tv1[i], $sformatf("single[%0d]", i));

      // Backpressure then resume
      rend = 17;
      for (int i = 0; i < 13; i++) apply_vec(tv2[i], $sformatf("bp[%0d]", i));
      cyc = 0;
      while (sidx < 17 && cyc < 100) begin
         drive(1'b0, 1'b1);
         tick();
         cyc++;
      end
      chk("bp_drain_done", sidx, 32'd17);

      // Continuous stream at full rate
      rend  = 33;
      first = -1;
      last  = -1;
      nv    = 0;
      maxl  = 0;
      for (int k = 0; k < 22; k++) begin
         drive(1'b0, 1'b1);
         if (m_valid) begin
            if (first < 0) first = k;
            last = k;
            nv++;
         end
         if (int'(level) > maxl) maxl = int'(level);
         tick();
      end
      chk("stream_first_valid", first, 32'd2);
      chk("stream_valid_count", nv, 32'd16);
      chk("stream_contiguous", last - first + 1, 32'd16);
      chk("stream_level_le1", {31'd0, maxl <= 1}, 32'd1);
      chk("stream_all_read", sidx, 32'd33);

      // Random ready and empty
      rend = 1033;
      maxl = 0;
      cyc  = 0;
      while (sidx < rend && cyc < 20000) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if (int'(level) > maxl) maxl = int'(level);
         tick();
         cyc++;
      end
      chk("rand_done", sidx, 32'd1033);
      chk("rand_level_le2", {31'd0, maxl <= 2}, 32'd1);
      chk("rand_err_ovf", {31'd0, err_ovf}, 32'd0);

      // Reset while full
      rend = 1041;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0);
      chk("prerst.level", {30'd0, level}, 32'd2);
      chk("prerst.data",  {24'd0, m_data}, {24'd0, src[1033]});
      rrst       = 1'b1;
      fifo_empty = 1'b1;
      #1;
      chk("midrst.valid", {31'd0, m_valid}, 32'd0);
      chk("midrst.level", {30'd0, level},   32'd0);
      chk("midrst.ren",   {31'd0, fifo_r_en}, 32'd0);
      tick();
      drive(1'b1, 1'b0);
      tick();
      rrst = 1'b0;
      sidx = ridx;
      drive(1'b0, 1'b1);
      chk("postrst.valid", {31'd0, m_valid}, 32'd0);
      tick();
      cyc = 0;
      while (sidx < rend && cyc < 100) begin
         drive(1'b0, 1'b1);
         tick();
         cyc++;
      end
      chk("postrst_done", sidx, 32'd1041);
      chk("final_err_ovf", {31'd0, err_ovf}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

`default_nettype wire
